// File: rtl/muldiv_controller.sv
// Multi-cycle multiply/divide unit that owns the HI/LO pair. It latches operands on accept,
// holds busy for a fixed cycle count, then commits the whole result in one edge.
module muldiv_controller #(
   parameter int unsigned MUL_CYCLES = 5,
   parameter int unsigned DIV_CYCLES = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        flush,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   typedef enum logic [1:0] {StIdle, StMul, StDiv} state_e;

   localparam logic [2:0] OpMult  = 3'd0;
   localparam logic [2:0] OpMultu = 3'd1;
   localparam logic [2:0] OpDiv   = 3'd2;
   localparam logic [2:0] OpDivu  = 3'd3;
   localparam logic [2:0] OpMthi  = 3'd4;
   localparam logic [2:0] OpMtlo  = 3'd5;

   state_e      state;
   logic [3:0]  cnt;
   logic [31:0] a_q;
   logic [31:0] b_q;
   logic        sgn_q;

   logic [63:0] a_ext;
   logic [63:0] b_ext;
   logic [63:0] prod;
   logic [31:0] abs_a;
   logic [31:0] abs_b;
   logic [31:0] q_mag;
   logic [31:0] r_mag;
   logic [31:0] div_hi;
   logic [31:0] div_lo;

   // Results are computed from the latched operands only, so the inputs may change freely.
   always_comb begin
      a_ext  = sgn_q ? {{32{a_q[31]}}, a_q} : {32'b0, a_q};
      b_ext  = sgn_q ? {{32{b_q[31]}}, b_q} : {32'b0, b_q};
      prod   = a_ext * b_ext;
      abs_a  = (sgn_q && a_q[31]) ? -a_q : a_q;
      abs_b  = (sgn_q && b_q[31]) ? -b_q : b_q;
      q_mag  = 32'd0;
      r_mag  = 32'd0;
      div_lo = 32'hFFFF_FFFF;
      div_hi = a_q;
      if (b_q != 32'd0) begin
         q_mag  = abs_a / abs_b;
         r_mag  = abs_a % abs_b;
         // Most-negative / -1 falls out naturally: magnitude 2^31 negates to itself.
         div_lo = (sgn_q && (a_q[31] ^ b_q[31])) ? -q_mag : q_mag;
         div_hi = (sgn_q && a_q[31]) ? -r_mag : r_mag;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= StIdle;
         cnt   <= 4'd0;
         busy  <= 1'b0;
         a_q   <= 32'd0;
         b_q   <= 32'd0;
         sgn_q <= 1'b0;
         hi    <= 32'd0;
         lo    <= 32'd0;
      end else if (flush) begin
         state <= StIdle;
         cnt   <= 4'd0;
         busy  <= 1'b0;
      end else begin
         unique case (state)
            StIdle: begin
               if (start) begin
                  case (op)
                     OpMult, OpMultu: begin
                        a_q   <= a;
                        b_q   <= b;
                        sgn_q <= ~op[0];
                        state <= StMul;
                        cnt   <= 4'(MUL_CYCLES - 1);
                        busy  <= 1'b1;
                     end
                     OpDiv, OpDivu: begin
                        a_q   <= a;
                        b_q   <= b;
                        sgn_q <= ~op[0];
                        state <= StDiv;
                        cnt   <= 4'(DIV_CYCLES - 1);
                        busy  <= 1'b1;
                     end
                     OpMthi:  hi <= a;
                     OpMtlo:  lo <= a;
                     default: ;
                  endcase
               end
            end
            StMul, StDiv: begin
               if (cnt == 4'd0) begin
                  if (state == StMul) begin
                     hi <= prod[63:32];
                     lo <= prod[31:0];
                  end else begin
                     hi <= div_hi;
                     lo <= div_lo;
                  end
                  state <= StIdle;
                  busy  <= 1'b0;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            default: begin
               state <= StIdle;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/muldiv_controller.md
# muldiv_controller

Multi-cycle multiply/divide controller owning the HI/LO register pair for the pipelined MIPS CPU. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the Execution stage, holds latched operands while an operation is in flight, and raises `busy` so the pipeline stall logic can hold dependent instructions (MFHI/MFLO and any new muldiv op) in E. HI/LO become architecturally visible only when the operation completes.

## Interface
- `MUL_CYCLES`, 5, cycles `busy` stays high for MULT/MULTU (legal 1..15)
- `DIV_CYCLES`, 10, cycles `busy` stays high for DIV/DIVU (legal 1..15)

- `clk`  input  1  single clock, all state updates on rising edge
- `reset`  input  1  asynchronous, active-low; clears all state immediately
- `start`  input  1  E-stage request valid (already gated with E bubble upstream)
- `op`  input  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO, others=no-op
- `a`  input  32  rs value (forwarded)
- `b`  input  32  rt value (forwarded)
- `flush`  input  1  synchronous abort of in-flight op
- `busy`  output  1  operation in flight; E stage must stall muldiv/MFHI/MFLO
- `hi`  output  32  HI register
- `lo`  output  32  LO register

## Operation
- States: IDLE, MUL, DIV. 4-bit down-counter `cnt`.
- IDLE, `start`=1, `flush`=0:
  - MULT/MULTU: latch `a`,`b`,signedness; state<=MUL; `cnt`<=MUL_CYCLES-1.
  - DIV/DIVU: latch; state<=DIV; `cnt`<=DIV_CYCLES-1.
  - MTHI: `hi`<=`a` at that edge; stay IDLE. MTLO: `lo`<=`a`; stay IDLE.
  - op 6/7: ignored.
- MUL/DIV: each edge `cnt`<=`cnt`-1; at edge where `cnt`==0, write result to `hi`/`lo`, state<=IDLE.
- `start` while busy: ignored entirely (pipeline contract forbids it; no queueing).
- Arithmetic on latched operands:
  - MULT: signed 32x32 -> 64; `hi`=[63:32], `lo`=[31:0]. MULTU: unsigned.
  - DIV: `lo`=quotient truncated toward zero, `hi`=remainder with sign of dividend. DIVU: unsigned.
  - Divide by zero (both signed/unsigned): `lo`=32'hFFFF_FFFF, `hi`=dividend.
  - DIV 32'h8000_0000 / 32'hFFFF_FFFF: `lo`=32'h8000_0000, `hi`=0.
- `flush`=1: state<=IDLE, `cnt`<=0, `hi`/`lo` unchanged, same-cycle `start` discarded (flush wins).
- `reset` low (any time, incl. mid-op): state=IDLE, `cnt`=0, `busy`=0, `hi`=0, `lo`=0, latched operands=0.

## Timing
- `busy` is registered: `busy`=(state!=IDLE). Low out of reset.
- Accepting edge T0: `busy` high from T0 through T0+N, N=MUL_CYCLES or DIV_CYCLES; i.e. high for exactly N cycles.
- Result visible in `hi`/`lo` after edge T0+N, same edge `busy` falls; a MFHI stalled in E reads the new value the first cycle `busy`=0.
- Back-to-back: new `start` accepted the cycle after `busy` falls (sampled at edge T0+N+1 earliest... i.e. the first edge where `busy`=0 beforehand); zero dead cycles beyond that.
- MTHI/MTLO: zero latency busy-wise; `hi`/`lo` updated at accepting edge, `busy` never asserted.
- `hi`/`lo` otherwise stable; never show partial results.
- Operand inputs are don't-care except on accepting edge.

## Test plan
- Reset: drive `reset`=0 mid-DIV (cnt=4) -> `busy`=0, `hi`=`lo`=0 immediately, before next clock edge.
- MULT a=32'hFFFF_FFFE (-2), b=3, MUL_CYCLES=5 -> `busy` high exactly 5 cycles; then `hi`=32'hFFFF_FFFF, `lo`=32'hFFFF_FFFA; MULTU same operands -> `hi`=2, `lo`=32'hFFFF_FFFA.
- DIV a=-7, b=2 -> after 10 busy cycles `lo`=32'hFFFF_FFFD (-3), `hi`=32'hFFFF_FFFF (-1); DIVU 7/0 -> `lo`=32'hFFFF_FFFF, `hi`=7; DIV 32'h8000_0000/-1 -> `lo`=32'h8000_0000, `hi`=0.
- MTHI a=32'h1234_5678 then MTLO a=32'h9ABC_DEF0 on consecutive cycles -> `hi`/`lo` updated on those edges, `busy` stays 0.
- `start` MULT asserted again while busy (different operands) -> ignored; result equals first op only; second `start` after `busy` falls accepted with no gap.
- `flush` at cycle 3 of MULT with prior `hi`=1,`lo`=2 -> `busy` falls next edge, `hi`=1,`lo`=2 preserved; `flush`+`start` same cycle -> nothing accepted.
